// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg
//   Shared definitions for the MCP3008-style ADC responder: the frame
//   state encoding, the configuration-word length and the default
//   widths used as parameter defaults by adc_spi_responder.
package adc_spi_pkg;

   // Frame states, in the order a well-formed frame walks through them.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_START,
      ST_CFG,
      ST_SAMPLE,
      ST_NULL,
      ST_DATA,
      ST_TAIL,
      ST_DONE
   } state_t;

   // SGL/DIFF + D2..D0 for the default 8-channel part.
   localparam int CFG_BITS = 4;

   localparam int DEF_CH_NUM      = 8;
   localparam int DEF_RES_BITS    = 10;
   localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync
//   Multi-flop synchronizer for one asynchronous SPI input plus one-clock
//   rise/fall pulses derived from the synchronized level.
// Ports
//   clk   in   system clock
//   rst   in   synchronous, active-high reset (chain loads RST_VAL)
//   d     in   asynchronous input
//   q     out  synchronized level
//   rise  out  1-clk pulse on a synchronized 0->1 transition
//   fall  out  1-clk pulse on a synchronized 1->0 transition
module spi_in_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic              prev_q;
   logic              prev_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
      prev_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign q    = sync_q[STAGES-1];
   assign rise = sync_q[STAGES-1] & ~prev_q;
   assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder
//   Emulates the ADC side of a 10-bit, 8-channel MCP3008-style SPI link.
//   CS/AD_CLK/DIN are oversampled in the clk domain; the responder decodes
//   START, SGL/DIFF and D2..D0, latches the selected conversion on the
//   following AD_CLK fall and shifts it out MSB-first after a null bit.
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   ad_clk, cs, din SPI from master (ad_clk idle low, cs active low)
//   dout, dout_oe   SPI data to master and its drive enable
//   ch_data         packed channel codes, ch n at [n*RES_BITS +: RES_BITS]
//   sample_ch       channel latched at the sample instant
//   sample_stb      1-clk pulse when the conversion value is latched
//   frame_done      1-clk pulse when the final bit of the frame is driven
//   frame_err       1-clk pulse when cs rises mid-frame
// Build option
//   ADC_LSB_TAIL_EN  after B0, also drive B1..B(RES_BITS-1) LSB-first and
//                    move frame_done to the last tail bit.
module adc_spi_responder
   import adc_spi_pkg::*;
#(
   parameter int CH_NUM      = DEF_CH_NUM,
   parameter int RES_BITS    = DEF_RES_BITS,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ad_clk,
   input  logic                         cs,
   input  logic                         din,
   output logic                         dout,
   output logic                         dout_oe,
   input  logic [CH_NUM*RES_BITS-1:0]   ch_data,
   output logic [$clog2(CH_NUM)-1:0]    sample_ch,
   output logic                         sample_stb,
   output logic                         frame_done,
   output logic                         frame_err
);

   localparam int IDX_W = $clog2(CH_NUM);
   localparam int CFG_W = 1 + IDX_W;
   localparam int CNT_W = $clog2(RES_BITS + CFG_W);

   // ---------------- input synchronizers ----------------
   logic sclk_q, sclk_rise, sclk_fall;
   logic cs_s, cs_rise, cs_fall;
   logic din_s, din_rise, din_fall;

   spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .d(ad_clk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
   // cs resets high so a reset never looks like a frame start.
   spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst(rst), .d(cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall));
   spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
      .clk(clk), .rst(rst), .d(din), .q(din_s), .rise(din_rise), .fall(din_fall));

   // Only levels of cs/din and edges of ad_clk matter to the protocol.
   logic unused_sync;
   assign unused_sync = ^{sclk_q, cs_rise, cs_fall, din_rise, din_fall};

   // ---------------- channel selection ----------------
   logic [RES_BITS-1:0] ch_arr [CH_NUM];

   genvar gi;
   generate
      for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
         assign ch_arr[gi] = ch_data[gi*RES_BITS +: RES_BITS];
      end
   endgenerate

   // ---------------- state ----------------
   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CFG_W-1:0]    cfg_q, cfg_d;
   logic [RES_BITS-1:0] result_q, result_d;
   logic                dout_q, dout_d;
   logic                oe_q, oe_d;
   logic [IDX_W-1:0]    sample_ch_q, sample_ch_d;
   logic                stb_q, stb_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic [IDX_W-1:0]    sel;
   logic [IDX_W-1:0]    pair;
   logic [RES_BITS-1:0] conv;

   // Differential mode pairs each channel with its LSB-flipped partner;
   // a negative difference saturates to zero.
   always_comb begin
      sel  = cfg_q[IDX_W-1:0];
      pair = sel ^ IDX_W'(1);
      if (cfg_q[CFG_W-1]) begin
         conv = ch_arr[sel];
      end else if (ch_arr[sel] > ch_arr[pair]) begin
         conv = ch_arr[sel] - ch_arr[pair];
      end else begin
         conv = '0;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cfg_d       = cfg_q;
      result_d    = result_q;
      dout_d      = dout_q;
      oe_d        = oe_q;
      sample_ch_d = sample_ch_q;
      stb_d       = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;

      if (cs_s) begin
         // cs high overrides any same-cycle ad_clk edge.
         state_d = ST_IDLE;
         dout_d  = 1'b0;
         oe_d    = 1'b0;
         if (state_q inside {ST_CFG, ST_SAMPLE, ST_NULL, ST_DATA, ST_TAIL}) begin
            err_d = 1'b1;
         end
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
               // Leading zero clocks are simply skipped.
               if (sclk_rise && din_s) begin
                  state_d = ST_CFG;
                  cnt_d   = '0;
               end
            end
            ST_CFG: begin
               if (sclk_rise) begin
                  cfg_d = {cfg_q[CFG_W-2:0], din_s};
                  if (cnt_q == CNT_W'(CFG_W-1)) begin
                     state_d = ST_SAMPLE;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            ST_SAMPLE: begin
               if (sclk_fall) begin
                  result_d    = conv;
                  sample_ch_d = sel;
                  stb_d       = 1'b1;
                  dout_d      = 1'b0;
                  oe_d        = 1'b1;
                  state_d     = ST_NULL;
               end
            end
            ST_NULL: begin
               if (sclk_fall) begin
                  dout_d  = result_q[RES_BITS-1];
                  cnt_d   = CNT_W'(RES_BITS-2);
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               if (sclk_fall) begin
                  dout_d = result_q[cnt_q];
                  if (cnt_q == '0) begin
`ifdef ADC_LSB_TAIL_EN
                     state_d = ST_TAIL;
                     cnt_d   = CNT_W'(1);
`else
                     done_d  = 1'b1;
                     state_d = ST_DONE;
`endif
                  end else begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
            end
`ifdef ADC_LSB_TAIL_EN
            ST_TAIL: begin
               if (sclk_fall) begin
                  dout_d = result_q[cnt_q];
                  if (cnt_q == CNT_W'(RES_BITS-1)) begin
                     done_d  = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
`endif
            ST_DONE: begin
               // The last bit stays on the wire until the master has had
               // its rising edge; the following fall releases the line.
               if (sclk_fall) begin
                  dout_d = 1'b0;
                  oe_d   = 1'b0;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cfg_q       <= '0;
         result_q    <= '0;
         dout_q      <= 1'b0;
         oe_q        <= 1'b0;
         sample_ch_q <= '0;
         stb_q       <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cfg_q       <= cfg_d;
         result_q    <= result_d;
         dout_q      <= dout_d;
         oe_q        <= oe_d;
         sample_ch_q <= sample_ch_d;
         stb_q       <= stb_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign dout       = dout_q;
   assign dout_oe    = oe_q;
   assign sample_ch  = sample_ch_q;
   assign sample_stb = stb_q;
   assign frame_done = done_q;
   assign frame_err  = err_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder
//   Drives SPI frames as a master would and compares the responder's
//   outputs with values computed from the channel codes by a small model.
module tb_adc_spi_responder;

   localparam int R    = 10;
   localparam int CH   = 8;
   localparam int HALF = 8;   // clk periods per AD_CLK half period
   localparam int SYNC = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            ad_clk;
   logic            cs;
   logic            din;
   logic            dout;
   logic            dout_oe;
   logic [CH*R-1:0] ch_data;
   logic [2:0]      sample_ch;
   logic            sample_stb;
   logic            frame_done;
   logic            frame_err;

   logic [R-1:0]    ch_mem [CH];

   int total = 0;
   int bad   = 0;
   int n_stb = 0;
   int n_done = 0;
   int n_err = 0;

   adc_spi_responder dut (
      .clk(clk), .rst(rst), .ad_clk(ad_clk), .cs(cs), .din(din),
      .dout(dout), .dout_oe(dout_oe), .ch_data(ch_data),
      .sample_ch(sample_ch), .sample_stb(sample_stb),
      .frame_done(frame_done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sample_stb === 1'b1) n_stb++;
      if (frame_done === 1'b1) n_done++;
      if (frame_err === 1'b1) n_err++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int idx, input logic [R-1:0] v);
      ch_mem[idx] = v;
      ch_data[idx*R +: R] = v;
   endtask

   // Expected conversion straight from the channel values.
   function automatic logic [R-1:0] model(input bit sgl, input logic [2:0] d);
      int a;
      int b;
      a = int'(ch_mem[d]);
      b = int'(ch_mem[d ^ 3'b001]);
      if (sgl) return R'(a);
      if (a > b) return R'(a - b);
      return '0;
   endfunction

   // One AD_CLK period: low phase (master samples dout at its end), then high.
   task automatic clk_bit(input logic din_v, input bit check, input logic exp_bit, input string tag);
      din = din_v;
      repeat (HALF) @(negedge clk);
      if (check) begin
         chk({tag, "_dout"}, 32'(dout), 32'(exp_bit));
         chk({tag, "_oe"}, 32'(dout_oe), 32'd1);
      end
      ad_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      ad_clk = 1'b0;
   endtask

   // abort_mode: 0 complete frame, 1 cs raised after abort_after data bits,
   // 2 reset pulsed after abort_after data bits.
   task automatic run_frame(input int nlead, input bit sgl, input logic [2:0] d,
                            input int abort_mode, input int abort_after, input bit scramble);
      logic [R-1:0] code;
      int s0;
      int d0;
      int e0;
      int nbits;
      code = model(sgl, d);
      s0 = n_stb;
      d0 = n_done;
      e0 = n_err;
      cs = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nlead; i++) clk_bit(1'b0, 1'b0, 1'b0, "lead");
      clk_bit(1'b1, 1'b0, 1'b0, "start");
      clk_bit(sgl, 1'b0, 1'b0, "sgl");
      clk_bit(d[2], 1'b0, 1'b0, "d2");
      clk_bit(d[1], 1'b0, 1'b0, "d1");
      clk_bit(d[0], 1'b0, 1'b0, "d0");
      clk_bit(1'b0, 1'b1, 1'b0, "null");
      if (scramble) begin
         for (int c = 0; c < CH; c++) set_ch(c, R'($urandom));
      end
      nbits = (abort_mode != 0) ? abort_after : R;
      for (int i = 0; i < nbits; i++) clk_bit(1'b0, 1'b1, code[R-1-i], "data");
      if (abort_mode == 0) begin
`ifdef ADC_LSB_TAIL_EN
         for (int i = 1; i < R; i++) clk_bit(1'b0, 1'b1, code[i], "tail");
`endif
         repeat (HALF) @(negedge clk);
         chk("post_oe", 32'(dout_oe), 32'd0);
         chk("post_dout", 32'(dout), 32'd0);
         cs = 1'b1;
         repeat (HALF) @(negedge clk);
         chk("stb_cnt", 32'(n_stb - s0), 32'd1);
         chk("done_cnt", 32'(n_done - d0), 32'd1);
         chk("err_cnt", 32'(n_err - e0), 32'd0);
         chk("sample_ch", 32'(sample_ch), 32'(d));
         $display("frame lead=%0d sgl=%0d ch=%0d code=%0h", nlead, sgl, d, code);
      end else if (abort_mode == 1) begin
         cs = 1'b1;
         repeat (SYNC + 2) @(negedge clk);
         chk("abort_oe", 32'(dout_oe), 32'd0);
         chk("abort_dout", 32'(dout), 32'd0);
         repeat (HALF) @(negedge clk);
         chk("abort_err", 32'(n_err - e0), 32'd1);
         chk("abort_done", 32'(n_done - d0), 32'd0);
         chk("abort_stb", 32'(n_stb - s0), 32'd1);
         $display("frame aborted by cs after %0d data bits ch=%0d", abort_after, d);
      end else begin
         rst = 1'b1;
         @(negedge clk);
         chk("rst_dout", 32'(dout), 32'd0);
         chk("rst_oe", 32'(dout_oe), 32'd0);
         chk("rst_ch", 32'(sample_ch), 32'd0);
         chk("rst_stb", 32'(sample_stb), 32'd0);
         chk("rst_done", 32'(frame_done), 32'd0);
         chk("rst_err", 32'(frame_err), 32'd0);
         rst = 1'b0;
         cs = 1'b1;
         repeat (HALF) @(negedge clk);
         chk("rst_err_cnt", 32'(n_err - e0), 32'd0);
         chk("rst_done_cnt", 32'(n_done - d0), 32'd0);
         $display("frame interrupted by reset after %0d data bits ch=%0d", abort_after, d);
      end
   endtask

   initial begin
      rst = 1'b1;
      ad_clk = 1'b0;
      cs = 1'b1;
      din = 1'b0;
      ch_data = '0;
      for (int c = 0; c < CH; c++) set_ch(c, '0);
      repeat (4) @(negedge clk);
      chk("reset_dout", 32'(dout), 32'd0);
      chk("reset_oe", 32'(dout_oe), 32'd0);
      chk("reset_ch", 32'(sample_ch), 32'd0);
      chk("reset_stb", 32'(sample_stb), 32'd0);
      chk("reset_done", 32'(frame_done), 32'd0);
      chk("reset_err", 32'(frame_err), 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // single-ended ch3
      set_ch(3, 10'h2A5);
      run_frame(0, 1'b1, 3'd3, 0, 0, 1'b0);
      // same request preceded by leading zeros
      run_frame(3, 1'b1, 3'd3, 0, 0, 1'b0);

      // differential, positive and saturated
      set_ch(2, 10'd500);
      set_ch(3, 10'd200);
      run_frame(0, 1'b0, 3'd2, 0, 0, 1'b0);
      run_frame(0, 1'b0, 3'd3, 0, 0, 1'b0);

      // cs abort after 4 data bits, then a clean frame
      set_ch(5, 10'h1C7);
      run_frame(0, 1'b1, 3'd5, 1, 4, 1'b0);
      run_frame(0, 1'b1, 3'd5, 0, 0, 1'b0);

      // reset in the middle of the data phase, then a clean frame
      set_ch(6, 10'h3F0);
      set_ch(7, 10'h00F);
      run_frame(0, 1'b0, 3'd6, 2, 3, 1'b0);
      run_frame(1, 1'b0, 3'd6, 0, 0, 1'b0);

      // end-of-data behaviour
      set_ch(0, 10'h301);
      run_frame(0, 1'b1, 3'd0, 0, 0, 1'b0);

      // random channel codes and requests; codes reshuffled after sampling
      for (int n = 0; n < 16; n++) begin
         for (int c = 0; c < CH; c++) set_ch(c, R'($urandom));
         run_frame(int'($urandom_range(0, 3)), 1'($urandom), 3'($urandom), 0, 0, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
